// File: rtl/output_limiter_pkg.sv
// Shared audio definitions for the output limiter: sample/gain widths, the limiter
// state codes decoded by the display logic, and the attack gain-floor helper.
package output_limiter_pkg;

  localparam int SAMPLE_W  = 18;
  localparam int MAG_W     = SAMPLE_W - 1;
  localparam int GAIN_W    = 8;
  localparam int GAIN_FRAC = 7;
  localparam int PROD_W    = 26;

  localparam logic [GAIN_W-1:0]          UNITY_GAIN = 8'd128;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 18'sh20000;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 18'sh1FFFF;
  localparam logic [MAG_W-1:0]           MAG_MAX    = 17'h1FFFF;

  localparam logic [1:0] LIM_UNITY   = 2'd0;
  localparam logic [1:0] LIM_ATTACK  = 2'd1;
  localparam logic [1:0] LIM_HOLD    = 2'd2;
  localparam logic [1:0] LIM_RELEASE = 2'd3;

  function automatic logic [GAIN_W-1:0] gain_after_attack(
    input logic [GAIN_W-1:0] g,
    input logic [GAIN_W-1:0] step,
    input logic [GAIN_W-1:0] floor_g
  );
    logic [GAIN_W:0] limit_s;
    limit_s = {1'b0, floor_g} + {1'b0, step};
    if ({1'b0, g} >= limit_s) begin
      return g - step;
    end else begin
      return floor_g;
    end
  endfunction

endpackage

// File: rtl/output_limiter_abs.sv
// abs_sat: signed sample to unsigned magnitude; the most negative code saturates to
// the largest positive magnitude instead of wrapping.
module abs_sat
  import output_limiter_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] x_i,
  output logic [MAG_W-1:0]           mag_o
);

  always_comb begin
    if (x_i == SAMPLE_MIN) begin
      mag_o = MAG_MAX;
    end else begin
      mag_o = (x_i[MAG_W-1:0] ^ {MAG_W{x_i[SAMPLE_W-1]}}) + {{(MAG_W-1){1'b0}}, x_i[SAMPLE_W-1]};
    end
  end

endmodule

// File: rtl/output_limiter.sv
// Post-mixer peak limiter: 3-stage gain pipeline, attack/hold/release gain FSM,
// sticky clip indicator and windowed coarse peak meter.
module output_limiter
  import output_limiter_pkg::*;
#(
  parameter logic [MAG_W-1:0]  THRESHOLD     = 17'd98304,
  parameter logic [GAIN_W-1:0] ATTACK_STEP   = 8'd8,
  parameter logic [GAIN_W-1:0] MIN_GAIN      = 8'd32,
  parameter logic [9:0]        HOLD_SAMPLES  = 10'd480,
  parameter logic [5:0]        RELEASE_DIV   = 6'd48,
  parameter int                PEAK_WIN_LOG2 = 10,
  parameter logic [12:0]       CLIP_HOLD     = 13'd4800
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ready,
  input  logic signed [SAMPLE_W-1:0] audio_in,
  input  logic                       bypass,
  output logic signed [SAMPLE_W-1:0] audio_out,
  output logic                       out_ready,
  output logic [GAIN_W-1:0]          gain,
  output logic                       limiting,
  output logic                       clip,
  output logic [4:0]                 peak_level
);

  localparam logic [PEAK_WIN_LOG2-1:0] WIN_LAST = {PEAK_WIN_LOG2{1'b1}};
  localparam logic [PEAK_WIN_LOG2-1:0] WIN_ONE  = PEAK_WIN_LOG2'(1);

  logic [MAG_W-1:0]           a_in_s;
  logic                       v1_q, v2_q;
  logic signed [SAMPLE_W-1:0] x1_q;
  logic [MAG_W-1:0]           a1_q;
  logic signed [SAMPLE_W-1:0] p2_q, p2_d;
  logic signed [PROD_W-1:0]   x_ext_s, g_ext_s;
  logic signed [SAMPLE_W-1:0] audio_out_q;
  logic                       out_ready_q;

  logic [1:0]                 state_q, state_d;
  logic [GAIN_W-1:0]          gain_q, gain_d, gain_inc_s;
  logic [9:0]                 hold_q, hold_d;
  logic [5:0]                 rel_q, rel_d;
  logic                       over_s, limiting_q;

  logic [12:0]                clip_cnt_q, clip_cnt_d;
  logic                       clip_q;
  logic [MAG_W-1:0]           pk_acc_q, pk_acc_d, pk_max_s;
  logic [PEAK_WIN_LOG2-1:0]   win_q, win_d;
  logic [4:0]                 peak_q, peak_d;

  abs_sat u_abs_sat (
    .x_i   (audio_in),
    .mag_o (a_in_s)
  );

  // s2 product uses the gain as it stood before this sample's FSM update
  assign x_ext_s    = PROD_W'(x1_q);
  assign g_ext_s    = PROD_W'($signed({1'b0, gain_q}));
  assign p2_d       = SAMPLE_W'((x_ext_s * g_ext_s) >>> GAIN_FRAC);
  assign over_s     = (a1_q >= THRESHOLD);
  assign gain_inc_s = gain_q + 8'd1;

  // Gain FSM: over always wins, bypass pins the limiter at unity
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    hold_d  = hold_q;
    rel_d   = rel_q;
    if (bypass) begin
      state_d = LIM_UNITY;
      gain_d  = UNITY_GAIN;
    end else if (v1_q && over_s) begin
      state_d = LIM_ATTACK;
      gain_d  = gain_after_attack(gain_q, ATTACK_STEP, MIN_GAIN);
      hold_d  = HOLD_SAMPLES;
    end else if (v1_q) begin
      case (state_q)
        LIM_ATTACK, LIM_HOLD: begin
          hold_d = hold_q - 10'd1;
          if (hold_q == 10'd1) begin
            state_d = LIM_RELEASE;
            rel_d   = RELEASE_DIV;
          end else begin
            state_d = LIM_HOLD;
          end
        end
        LIM_RELEASE: begin
          if (rel_q == 6'd1) begin
            gain_d  = gain_inc_s;
            rel_d   = RELEASE_DIV;
            state_d = (gain_inc_s == UNITY_GAIN) ? LIM_UNITY : LIM_RELEASE;
          end else begin
            rel_d   = rel_q - 6'd1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (v1_q && ((x1_q == SAMPLE_MIN) || (x1_q == SAMPLE_MAX))) begin
      clip_cnt_d = CLIP_HOLD;
    end else if (v1_q && (clip_cnt_q != 13'd0)) begin
      clip_cnt_d = clip_cnt_q - 13'd1;
    end else begin
      clip_cnt_d = clip_cnt_q;
    end
  end

  // Peak window: the closing sample is folded into the reported level
  always_comb begin
    pk_max_s = (a1_q > pk_acc_q) ? a1_q : pk_acc_q;
    pk_acc_d = pk_acc_q;
    win_d    = win_q;
    peak_d   = peak_q;
    if (v1_q) begin
      win_d = win_q + WIN_ONE;
      if (win_q == WIN_LAST) begin
        peak_d   = pk_max_s[MAG_W-1:MAG_W-5];
        pk_acc_d = {MAG_W{1'b0}};
      end else begin
        pk_acc_d = pk_max_s;
      end
    end else begin
      pk_acc_d = pk_acc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      v1_q        <= 1'b0;
      x1_q        <= {SAMPLE_W{1'b0}};
      a1_q        <= {MAG_W{1'b0}};
      v2_q        <= 1'b0;
      p2_q        <= {SAMPLE_W{1'b0}};
      audio_out_q <= {SAMPLE_W{1'b0}};
      out_ready_q <= 1'b0;
      state_q     <= LIM_UNITY;
      gain_q      <= UNITY_GAIN;
      hold_q      <= 10'd0;
      rel_q       <= 6'd0;
      limiting_q  <= 1'b0;
      clip_cnt_q  <= 13'd0;
      clip_q      <= 1'b0;
      pk_acc_q    <= {MAG_W{1'b0}};
      win_q       <= {PEAK_WIN_LOG2{1'b0}};
      peak_q      <= 5'd0;
    end else begin
      v1_q <= ready;
      if (ready) begin
        x1_q <= audio_in;
        a1_q <= a_in_s;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        p2_q <= p2_d;
      end
      out_ready_q <= v2_q;
      if (v2_q) begin
        audio_out_q <= p2_q;
      end
      state_q    <= state_d;
      gain_q     <= gain_d;
      hold_q     <= hold_d;
      rel_q      <= rel_d;
      limiting_q <= (state_d != LIM_UNITY);
      clip_cnt_q <= clip_cnt_d;
      clip_q     <= (clip_cnt_d != 13'd0);
      pk_acc_q   <= pk_acc_d;
      win_q      <= win_d;
      peak_q     <= peak_d;
    end
  end

  assign audio_out  = audio_out_q;
  assign out_ready  = out_ready_q;
  assign gain       = gain_q;
  assign limiting   = limiting_q;
  assign clip       = clip_q;
  assign peak_level = peak_q;

endmodule

// File: tb/tb_output_limiter.sv
// Bench for output_limiter: table vectors, hand sequences for the hold/release, clip
// and meter corners, and random streams against a sample-level reference model.
module tb_output_limiter;

  logic                clock = 1'b0;
  logic                reset, ready, bypass;
  logic signed [17:0]  audio_in;
  logic signed [17:0]  audio_out;
  logic                out_ready;
  logic [7:0]          gain;
  logic                limiting, clip;
  logic [4:0]          peak_level;

  output_limiter dut (
    .clock      (clock),
    .reset      (reset),
    .ready      (ready),
    .audio_in   (audio_in),
    .bypass     (bypass),
    .audio_out  (audio_out),
    .out_ready  (out_ready),
    .gain       (gain),
    .limiting   (limiting),
    .clip       (clip),
    .peak_level (peak_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    bit byp;
    int exp_out;
    int exp_gain;
    int exp_lim;
    int exp_clip;
  } vec_t;

  vec_t vecs[13];
  int   checks = 0;
  int   failures = 0;
  int   exp_q[$];
  int   last_out = 0;

  // Reference model: gain is a function of the gain left by the last over sample
  // and the count of quiet samples since then.
  int m_g0, m_quiet, m_since_clip, m_pk, m_win, m_level;
  bit m_seen_over, m_seen_clip;

  function automatic int model_gain();
    int g;
    if (!m_seen_over) return 128;
    if (m_quiet < 480) return m_g0;
    g = m_g0 + (m_quiet - 480) / 48;
    return (g > 128) ? 128 : g;
  endfunction

  function automatic int model_limiting();
    return (m_seen_over && model_gain() < 128) ? 1 : 0;
  endfunction

  function automatic int model_clip();
    return (m_seen_clip && m_since_clip < 4800) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_g0 = 128; m_quiet = 0; m_seen_over = 1'b0;
    m_since_clip = 0; m_seen_clip = 1'b0;
    m_pk = 0; m_win = 0; m_level = 0;
  endtask

  task automatic model_sample(input int x);
    int a, g, nxt;
    a = (x < 0) ? -x : x;
    if (a > 131071) a = 131071;
    g = bypass ? 128 : model_gain();
    exp_q.push_back((x * g) >>> 7);   // floor division by 128
    if (bypass) begin
      m_seen_over = 1'b0;
    end else if (a >= 98304) begin
      nxt = model_gain() - 8;
      m_g0 = (nxt < 32) ? 32 : nxt;
      m_quiet = 0;
      m_seen_over = 1'b1;
    end else begin
      m_quiet++;
    end
    if (x == -131072 || x == 131071) begin
      m_seen_clip = 1'b1;
      m_since_clip = 0;
    end else begin
      m_since_clip++;
    end
    if (a > m_pk) m_pk = a;
    m_win++;
    if (m_win == 1024) begin
      m_level = m_pk >> 12;
      m_pk = 0;
      m_win = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: output strobes are checked at the falling edge, then the rising edge samples inputs.
  task automatic cycle();
    @(negedge clock);
    if (out_ready === 1'b1) begin
      last_out = audio_out;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe audio_out=%0d with no sample pending", audio_out);
      end else begin
        check("audio_out", audio_out, exp_q.pop_front());
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input int x);
    audio_in = 18'(x);
    ready = 1'b1;
    model_sample(x);
    cycle();
    ready = 1'b0;
  endtask

  task automatic send_n(input int x, input int n);
    for (int i = 0; i < n; i++) send(x);
  endtask

  task automatic status_check(input string tag);
    check({tag, "_gain"}, gain, model_gain());
    check({tag, "_limiting"}, limiting, model_limiting());
    check({tag, "_clip"}, clip, model_clip());
    check({tag, "_peak"}, peak_level, m_level);
  endtask

  task automatic drain(input string tag);
    idle(6);
    check({tag, "_pending"}, exp_q.size(), 0);
    status_check(tag);
  endtask

  // Reset held three cycles with ready toggling; the first reset edge drops in-flight samples.
  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ready = (i != 1);
      audio_in = 18'sd1000;
      cycle();
      if (i == 0) exp_q.delete();
    end
    reset = 1'b1;
    ready = 1'b0;
    model_reset();
  endtask

  task automatic reach_release_edge();
    do_reset();
    send_n(120000, 12);
    drain("attack_floor");
    check("attack_floor_const", gain, 32);
    send_n(0, 479);
    drain("hold_479");
    check("hold_479_lim_const", limiting, 1);
    send_n(0, 48);
    drain("release_start");
    check("release_start_const", gain, 32);
    send(0);
    drain("release_step1");
    check("release_step1_const", gain, 33);
    send_n(0, 94 * 48 + 47);
    drain("release_127");
    check("release_127_const", gain, 127);
  endtask

  function automatic int rand_x(input int over_pm);
    int r, m;
    r = $urandom_range(999, 0);
    if (r < 6) begin
      case ($urandom_range(2, 0))
        0: return -131072;
        1: return 131071;
        default: return -131071;
      endcase
    end
    if (r < 6 + over_pm) m = $urandom_range(131071, 98304);
    else m = $urandom_range(98303, 0);
    return ($urandom_range(1, 0) == 1) ? -m : m;
  endfunction

  initial begin
    reset = 1'b0; ready = 1'b0; bypass = 1'b0; audio_in = 18'sd0;
    model_reset();

    vecs[0]  = '{1000,    1'b0, 1000,    128, 0, 0};
    vecs[1]  = '{-1000,   1'b0, -1000,   128, 0, 0};
    vecs[2]  = '{0,       1'b0, 0,       128, 0, 0};
    vecs[3]  = '{98303,   1'b0, 98303,   128, 0, 0};
    vecs[4]  = '{98304,   1'b0, 98304,   120, 1, 0};
    vecs[5]  = '{-98304,  1'b0, -98304,  120, 1, 0};
    vecs[6]  = '{120000,  1'b0, 120000,  120, 1, 0};
    vecs[7]  = '{131071,  1'b0, 131071,  120, 1, 1};
    vecs[8]  = '{-131072, 1'b0, -131072, 120, 1, 1};
    vecs[9]  = '{-131071, 1'b0, -131071, 120, 1, 0};
    vecs[10] = '{120000,  1'b1, 120000,  128, 0, 0};
    vecs[11] = '{-131072, 1'b1, -131072, 128, 0, 1};
    vecs[12] = '{-1,      1'b0, -1,      128, 0, 0};

    // Reset values, and no strobe while or after reset with ready toggling
    do_reset();
    check("rst_audio_out", audio_out, 0);
    check("rst_out_ready", out_ready, 0);
    status_check("rst");
    check("rst_gain_const", gain, 128);
    idle(5);

    for (int i = 0; i < 13; i++) begin
      do_reset();
      bypass = vecs[i].byp;
      idle(1);
      last_out = 12345;
      send(vecs[i].x);
      drain("vec");
      check("vec_out", last_out, vecs[i].exp_out);
      check("vec_gain", gain, vecs[i].exp_gain);
      check("vec_limiting", limiting, vecs[i].exp_lim);
      check("vec_clip", clip, vecs[i].exp_clip);
      bypass = 1'b0;
    end

    // Back-to-back attack: second sample sees the already-reduced gain
    do_reset();
    send_n(120000, 2);
    drain("attack2");
    check("attack2_out", last_out, 112500);
    check("attack2_gain", gain, 112);
    send_n(120000, 18);
    drain("attack20");
    check("attack20_gain", gain, 32);

    // Release completes to unity
    reach_release_edge();
    send(0);
    drain("release_done");
    check("release_done_gain", gain, 128);
    check("release_done_lim", limiting, 0);

    // Over wins on the sample that would otherwise finish the release
    reach_release_edge();
    send(-120000);
    drain("release_over");
    check("release_over_out", last_out, -119063);
    check("release_over_gain", gain, 119);
    check("release_over_lim", limiting, 1);

    // Clip hold and peak window
    do_reset();
    send(-131072);
    send_n(0, 1022);
    drain("win_1023");
    check("win_1023_peak", peak_level, 0);
    check("win_1023_clip", clip, 1);
    send(0);
    drain("win_1024");
    check("win_1024_peak", peak_level, 31);
    send_n(0, 3776);
    drain("clip_4799");
    check("clip_4799_const", clip, 1);
    send(0);
    drain("clip_4800");
    check("clip_4800_const", clip, 0);

    // Reset during release with samples in flight, then bypass
    do_reset();
    send_n(120000, 12);
    send_n(0, 500);
    send(5000);
    send(6000);
    do_reset();
    check("midrst_gain", gain, 128);
    check("midrst_lim", limiting, 0);
    idle(6);
    check("midrst_out_ready", out_ready, 0);
    bypass = 1'b1;
    idle(1);
    last_out = 0;
    send_n(120000, 3);
    drain("bypass");
    check("bypass_out", last_out, 120000);
    check("bypass_lim", limiting, 0);
    bypass = 1'b0;

    // Random streams with idle gaps
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      bypass = (seg == 2);
      idle(2);
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(3, 0) == 0) idle(1);
        else send(rand_x((seg == 0) ? 100 : 2));
      end
      drain("random");
    end
    bypass = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
